// File: rtl/aes_out_serializer.sv
// aes_out_serializer: buffers 128-bit AES result blocks in a small FIFO and
// streams each block as four 32-bit words over a valid/ready interface.
// Optional feature macro: AES_OUT_PARITY_EN adds a registered per-byte parity
// output (ser_parity) aligned with ser_word.
module aes_out_serializer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic         AES_clk,
  input  logic         AES_rst,
  input  logic [127:0] AES_data_out,
  input  logic         AES_data_out_valid,
  output logic [31:0]  ser_word,
  output logic         ser_valid,
  output logic         ser_last,
  input  logic         ser_ready,
  output logic [AW:0]  ser_level,
  output logic         ser_overflow,
  input  logic         ser_ovf_clr
`ifdef AES_OUT_PARITY_EN
  ,
  output logic [3:0]   ser_parity
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  state_t        state_q;
  state_t        state_d;

  logic          valid_prev;
  logic          capture;
  logic          full;
  logic          xfer;
  logic          pop;
  logic          wr_en;
  logic          drop;

  logic [127:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_inc;
  logic [1:0]    word_idx;

  logic [31:0]   word_d;
  logic [1:0]    idx_d;
  logic          last_d;

  // Selects one 32-bit word of a block, most significant word first
  function automatic logic [31:0] word_sel(input logic [127:0] blk, input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction

  // A held-high valid from the AES core counts once: only its rising edge captures
  assign capture    = AES_data_out_valid & ~valid_prev;
  assign full       = (ser_level == LVL_FULL);
  assign xfer       = ser_valid & ser_ready;
  assign pop        = xfer & (word_idx == 2'd3);
  // A pop in the same cycle frees the slot, so a capture into a full FIFO still fits
  assign wr_en      = capture & (~full | pop);
  assign drop       = capture & full & ~pop;
  assign rd_ptr_inc = rd_ptr + PTR_ONE;

  // Remember the previous AES valid for rising-edge detection
  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      valid_prev <= 1'b0;
    end else begin
      valid_prev <= AES_data_out_valid;
    end
  end

  // Block storage; contents need no reset because the pointers define occupancy
  always_ff @(posedge AES_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= AES_data_out;
    end
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ser_level <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr_inc;
      end
      case ({wr_en, pop})
        2'b10:   ser_level <= ser_level + LVL_ONE;
        2'b01:   ser_level <= ser_level - LVL_ONE;
        default: ser_level <= ser_level;
      endcase
    end
  end

  // Sticky overflow flag; a new drop wins over a simultaneous clear
  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      ser_overflow <= 1'b0;
    end else if (drop) begin
      ser_overflow <= 1'b1;
    end else if (ser_ovf_clr) begin
      ser_overflow <= 1'b0;
    end
  end

  // Next state and next output word; new words only load when the current one is taken or absent
  always_comb begin
    state_d = state_q;
    word_d  = ser_word;
    idx_d   = word_idx;
    last_d  = ser_last;
    case (state_q)
      IDLE: begin
        if (wr_en) begin
          state_d = SEND;
          word_d  = AES_data_out[127:96];
          idx_d   = 2'd0;
          last_d  = 1'b0;
        end
      end
      SEND: begin
        if (xfer) begin
          if (word_idx != 2'd3) begin
            idx_d  = word_idx + 2'd1;
            word_d = word_sel(mem[rd_ptr], word_idx + 2'd1);
            last_d = (word_idx == 2'd2);
          end else if (ser_level > LVL_ONE) begin
            idx_d  = 2'd0;
            word_d = word_sel(mem[rd_ptr_inc], 2'd0);
            last_d = 1'b0;
          end else if (wr_en) begin
            idx_d  = 2'd0;
            word_d = AES_data_out[127:96];
            last_d = 1'b0;
          end else begin
            state_d = IDLE;
            idx_d   = 2'd0;
            last_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 2'd0;
        last_d  = 1'b0;
      end
    endcase
  end

  // State register and registered output word, so ser_ready never reaches ser_valid combinationally
  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      state_q   <= IDLE;
      ser_valid <= 1'b0;
      ser_word  <= '0;
      ser_last  <= 1'b0;
      word_idx  <= '0;
    end else begin
      state_q   <= state_d;
      ser_valid <= (state_d == SEND);
      ser_word  <= word_d;
      ser_last  <= last_d;
      word_idx  <= idx_d;
    end
  end

`ifdef AES_OUT_PARITY_EN
  // Per-byte XOR parity, registered alongside the word it describes
  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      ser_parity <= '0;
    end else begin
      ser_parity <= {^word_d[31:24], ^word_d[23:16], ^word_d[15:8], ^word_d[7:0]};
    end
  end
`endif

endmodule

// File: tb/tb_aes_out_serializer.sv
// Testbench for aes_out_serializer: directed vector table, hand-written
// corner sequences and randomized traffic checked against a queue-based model.
module tb_aes_out_serializer;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic         AES_clk;
  logic         AES_rst;
  logic [127:0] AES_data_out;
  logic         AES_data_out_valid;
  logic [31:0]  ser_word;
  logic         ser_valid;
  logic         ser_last;
  logic         ser_ready;
  logic [AW:0]  ser_level;
  logic         ser_overflow;
  logic         ser_ovf_clr;
`ifdef AES_OUT_PARITY_EN
  logic [3:0]   ser_parity;
`endif

  aes_out_serializer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .AES_clk            (AES_clk),
    .AES_rst            (AES_rst),
    .AES_data_out       (AES_data_out),
    .AES_data_out_valid (AES_data_out_valid),
    .ser_word           (ser_word),
    .ser_valid          (ser_valid),
    .ser_last           (ser_last),
    .ser_ready          (ser_ready),
    .ser_level          (ser_level),
    .ser_overflow       (ser_overflow),
    .ser_ovf_clr        (ser_ovf_clr)
`ifdef AES_OUT_PARITY_EN
    ,
    .ser_parity         (ser_parity)
`endif
  );

  initial AES_clk = 1'b0;
  always #5 AES_clk = ~AES_clk;

  int nchecks = 0;
  int nerrors = 0;

  // Reference model: queue of stored blocks, head is the block being sent
  logic [127:0] mq[$];
  int           m_idx  = 0;
  bit           m_prev = 1'b0;
  bit           m_ovf  = 1'b0;

  localparam logic [127:0] B1 = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
  localparam logic [127:0] B2 = 128'h00112233_44556677_8899aabb_ccddeeff;

  typedef struct {
    logic         vin;
    logic [127:0] data;
    logic         rdy;
    logic         exp_valid;
    logic [31:0]  exp_word;
    logic         exp_last;
    logic [AW:0]  exp_level;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_word();
    logic [127:0] b;
    b = mq[0];
    return b[127-32*m_idx -: 32];
  endfunction

  function automatic logic [3:0] par_of(input logic [31:0] w);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = ^w[8*i +: 8];
    return p;
  endfunction

  task automatic modelReset();
    mq.delete();
    m_idx  = 0;
    m_prev = 1'b0;
    m_ovf  = 1'b0;
  endtask

  // Advance the model by one clock using the inputs the DUT sees at that edge
  task automatic modelStep(input logic vin, input logic [127:0] d, input logic rdy, input logic clr);
    bit set_ovf;
    set_ovf = 1'b0;
    if (mq.size() > 0 && rdy) begin
      if (m_idx == 3) begin
        mq.delete(0);
        m_idx = 0;
      end else begin
        m_idx++;
      end
    end
    if (vin && !m_prev) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else set_ovf = 1'b1;
    end
    if (set_ovf) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_prev = vin;
  endtask

  task automatic applyStimulus(input logic vin, input logic [127:0] d, input logic rdy, input logic clr);
    AES_data_out_valid = vin;
    AES_data_out       = d;
    ser_ready          = rdy;
    ser_ovf_clr        = clr;
    modelStep(vin, d, rdy, clr);
    @(posedge AES_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".valid"}, ser_valid, mq.size() > 0);
    check({tag, ".level"}, ser_level, mq.size());
    check({tag, ".ovf"}, ser_overflow, m_ovf);
    check({tag, ".last"}, ser_last, (mq.size() > 0) && (m_idx == 3));
    if (mq.size() > 0) begin
      check({tag, ".word"}, ser_word, m_word());
`ifdef AES_OUT_PARITY_EN
      check({tag, ".parity"}, ser_parity, par_of(m_word()));
`endif
    end
  endtask

  initial begin
    logic [31:0]  got[$];
    logic [127:0] blk[5];
    logic [127:0] b;
    int           rdy_pct;

    vecs[0]  = '{1'b1, B1,   1'b1, 1'b1, 32'h69c4e0d8, 1'b0, 3'd1};
    vecs[1]  = '{1'b0, '0,   1'b1, 1'b1, 32'h6a7b0430, 1'b0, 3'd1};
    vecs[2]  = '{1'b0, '0,   1'b1, 1'b1, 32'hd8cdb780, 1'b0, 3'd1};
    vecs[3]  = '{1'b0, '0,   1'b1, 1'b1, 32'h70b4c55a, 1'b1, 3'd1};
    vecs[4]  = '{1'b0, '0,   1'b1, 1'b0, 32'h0,        1'b0, 3'd0};
    vecs[5]  = '{1'b1, B2,   1'b1, 1'b1, 32'h00112233, 1'b0, 3'd1};
    vecs[6]  = '{1'b1, B2,   1'b1, 1'b1, 32'h44556677, 1'b0, 3'd1};
    vecs[7]  = '{1'b1, B2,   1'b1, 1'b1, 32'h8899aabb, 1'b0, 3'd1};
    vecs[8]  = '{1'b1, B2,   1'b1, 1'b1, 32'hccddeeff, 1'b1, 3'd1};
    vecs[9]  = '{1'b1, B2,   1'b1, 1'b0, 32'h0,        1'b0, 3'd0};
    vecs[10] = '{1'b0, '0,   1'b1, 1'b0, 32'h0,        1'b0, 3'd0};

    AES_rst            = 1'b1;
    AES_data_out       = '0;
    AES_data_out_valid = 1'b0;
    ser_ready          = 1'b0;
    ser_ovf_clr        = 1'b0;
    modelReset();
    repeat (2) @(posedge AES_clk);
    #1;
    AES_rst = 1'b0;

    check("reset.valid", ser_valid, 1'b0);
    check("reset.word", ser_word, 32'h0);
    check("reset.last", ser_last, 1'b0);
    check("reset.level", ser_level, 3'd0);
    check("reset.ovf", ser_overflow, 1'b0);

    // Directed vectors: single block and a valid held for five cycles
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].vin, vecs[i].data, vecs[i].rdy, 1'b0);
      check($sformatf("vec%0d.valid", i), ser_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d.level", i), ser_level, vecs[i].exp_level);
      check($sformatf("vec%0d.last", i), ser_last, vecs[i].exp_last);
      if (vecs[i].exp_valid) check($sformatf("vec%0d.word", i), ser_word, vecs[i].exp_word);
`ifdef AES_OUT_PARITY_EN
      if (i == 0) check("vec0.parity", ser_parity, 4'b0110);
`endif
    end

    // Backpressure mid-block: ready low three cycles, then toggling 1010
    b = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(1'b1, b, 1'b1, 1'b0);
    checkOutput("bp.cap");
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("bp.w1");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("bp.stall");
      check("bp.hold", ser_word, b[95:64]);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, '0, (i % 2 == 0), 1'b0);
      checkOutput("bp.toggle");
    end
    check("bp.empty", ser_valid, 1'b0);

    // Overflow: five distinct blocks with the consumer stalled
    for (int k = 0; k < 5; k++) begin
      blk[k] = {$urandom, $urandom, $urandom, 24'h0, 8'(k)};
      applyStimulus(1'b1, blk[k], 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("ovf.fill");
    end
    check("ovf.level", ser_level, 3'd4);
    check("ovf.flag", ser_overflow, 1'b1);
    got.delete();
    for (int i = 0; i < 20; i++) begin
      if (ser_valid) got.push_back(ser_word);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("ovf.drain");
    end
    check("ovf.count", got.size(), 16);
    for (int i = 0; i < 16 && i < got.size(); i++) begin
      b = blk[i/4];
      check($sformatf("ovf.order%0d", i), got[i], b[127-32*(i%4) -: 32]);
    end
    check("ovf.sticky", ser_overflow, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    check("ovf.clr", ser_overflow, 1'b0);

    // Full FIFO: final-word pop and a new capture in the same cycle
    for (int k = 0; k < 4; k++) begin
      blk[k] = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(1'b1, blk[k], 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
    end
    check("full.level", ser_level, 3'd4);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    check("full.last", ser_last, 1'b1);
    blk[4] = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(1'b1, blk[4], 1'b1, 1'b0);
    checkOutput("full.popcap");
    check("full.level4", ser_level, 3'd4);
    check("full.noovf", ser_overflow, 1'b0);
    got.delete();
    for (int i = 0; i < 20; i++) begin
      if (ser_valid) got.push_back(ser_word);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("full.drain");
    end
    check("full.count", got.size(), 16);
    for (int i = 0; i < 4 && got.size() == 16; i++)
      check($sformatf("full.new%0d", i), got[12+i], blk[4][127-32*i -: 32]);

    // Asynchronous reset after the second word of a block
    b = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(1'b1, b, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    check("rst.pre", ser_word, b[63:32]);
    blk[0] = {$urandom, $urandom, $urandom, $urandom};
    AES_data_out_valid = 1'b1;
    AES_data_out       = blk[0];
    AES_rst            = 1'b1;
    modelReset();
    #2;
    check("rst.valid", ser_valid, 1'b0);
    check("rst.word", ser_word, 32'h0);
    check("rst.last", ser_last, 1'b0);
    check("rst.level", ser_level, 3'd0);
    @(posedge AES_clk);
    #1;
    AES_rst = 1'b0;
    applyStimulus(1'b1, blk[0], 1'b1, 1'b0);
    checkOutput("rst.restart");
    check("rst.first", ser_word, blk[0][127:96]);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("rst.drain");
    end

    // Randomized traffic against the model, alternating slow and fast consumers
    for (int i = 0; i < 800; i++) begin
      rdy_pct = ((i / 100) % 2 == 0) ? 25 : 85;
      applyStimulus($urandom_range(0, 2) == 0,
                    {$urandom, $urandom, $urandom, $urandom},
                    $urandom_range(0, 99) < rdy_pct,
                    $urandom_range(0, 31) == 0);
      checkOutput("rand");
    end

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule
